// File: rtl/fifo_pkg.sv
// Shared types and helpers for the read-side FIFO drain logic.
package fifo_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_rd_drain_skid.sv
// Two-entry output buffer with occupancy FSM; head register drives the stream data.
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATASIZE = 8
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                push,
    input  logic                pop,
    input  logic [DATASIZE-1:0] din,
    output logic [DATASIZE-1:0] head,
    output occ_e                occ,
    output logic                full
);

    occ_e                occ_q, occ_d;
    logic [DATASIZE-1:0] head_q, head_d;
    logic [DATASIZE-1:0] slot1_q, slot1_d;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        occ_d   = occ_q;
        head_d  = head_q;
        slot1_d = slot1_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    occ_d  = OCC_ONE;
                    head_d = din;
                end
            end
            OCC_ONE: begin
                if (push && !pop) begin
                    occ_d   = OCC_TWO;
                    slot1_d = din;
                end else if (pop && !push) begin
                    occ_d = OCC_EMPTY;
                end else if (push && pop) begin
                    head_d = din;
                end
            end
            OCC_TWO: begin
                if (pop) begin
                    occ_d  = OCC_ONE;
                    head_d = slot1_q;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            occ_q   <= OCC_EMPTY;
            head_q  <= '0;
            // NOTE: slot1 is only read after a push fills it, but clearing it keeps reset state deterministic.
            slot1_q <= '0;
        end else begin
            occ_q   <= occ_d;
            head_q  <= head_d;
            slot1_q <= slot1_d;
        end
    end

    assign head = head_q;
    assign occ  = occ_q;
    assign full = (occ_q == OCC_TWO);

endmodule

// File: rtl/fifo_rd_drain.sv
// Drains the show-ahead FIFO read port into a registered valid/ready stream with burst framing.
module fifo_rd_drain
    import fifo_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int BURSTLEN = 16,
    parameter int CNTSIZE  = 16
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rd_en,
    input  logic [DATASIZE-1:0] rdata,
    input  logic                rempty,
    output logic                rinc,
    output logic [DATASIZE-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic [CNTSIZE-1:0]  word_cnt
);

    localparam int                 BEAT_W    = cnt_width(BURSTLEN);
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BURSTLEN - 1);

    occ_e              occ;
    logic              full;
    logic              pop;
    logic [BEAT_W-1:0] beat_cnt;

    // Pop decision uses only registered occupancy and FIFO/flow inputs, never m_ready.
    assign rinc    = !rrst && rd_en && !rempty && !full;
    assign m_valid = !rrst && (occ != OCC_EMPTY);
    assign pop     = m_valid && m_ready;
    assign m_last  = m_valid && (beat_cnt == LAST_BEAT);

    rd_skid_buf #(
        .DATASIZE (DATASIZE)
    ) u_skid (
        .rclk (rclk),
        .rrst (rrst),
        .push (rinc),
        .pop  (pop),
        .din  (rdata),
        .head (m_data),
        .occ  (occ),
        .full (full)
    );

    always_ff @(posedge rclk) begin
        if (rrst) begin
            beat_cnt <= '0;
            word_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            word_cnt <= word_cnt + 1'b1;
        end
    end

endmodule
